serializador_2b: RTL

Converts 8-bit parallel words into a 2-bit-wide serial symbol stream, one symbol per `clk16f` cycle, most-significant pair first. It sits directly downstream of the parallel data path and drives the 2-bit lane, all in the `clk16f` domain. After reset it emits a fixed alignment preamble, then transmits buffered data words or IDLE fill words. Upstream producers use a 2-entry input buffer with ready/valid flow control to hand words over without stalling on word boundaries.

---
 rtl/serializador_2b.sv | 127 ++++++++++++
 1 files changed

// File: rtl/serializador_2b.sv
// 8-bit parallel to 2-bit serial lane, MS pair first, with alignment preamble,
// IDLE fill and a 2-entry ready/valid input buffer.
module serializador_2b #(
    parameter logic [7:0]  COM        = 8'hBC,
    parameter logic [7:0]  IDLE       = 8'h7C,
    parameter int unsigned SYNC_WORDS = 4
) (
    input  logic       clk16f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic [1:0] data_out,
    output logic       word_start,
    output logic       valid_out,
    output logic       sync_done
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned DEPTH   = 2;
    localparam int unsigned WORD_W  = 8;

    typedef enum logic {SYNC, RUN} state_t;

    state_t                   state;
    state_t                   state_next;
    logic [1:0]               phase;
    logic [CNT_W-1:0]         sync_cnt;
    logic [WORD_W-1:0]        buf_mem [DEPTH];
    logic                     rd_ptr;
    logic                     wr_ptr;
    logic [1:0]               count;
    logic [WORD_W-3:0]        shreg;
    logic                     load;
    logic                     push;
    logic                     pop;
    logic [WORD_W-1:0]        next_word;
    logic                     next_valid;

    assign load      = (phase == 2'd0);
    assign ready_out = (count < 2'(DEPTH));
    assign push      = valid_in && ready_out;

    // State register
    always_ff @(posedge clk16f or posedge reset) begin
        if (reset) begin
            state <= SYNC;
        end else begin
            state <= state_next;
        end
    end

    // Next state and word selection for the upcoming load edge
    always_comb begin
        state_next = state;
        next_word  = IDLE;
        next_valid = 1'b0;
        pop        = 1'b0;
        case (state)
            SYNC: begin
                next_word = COM;
                if (load && (sync_cnt == CNT_W'(SYNC_WORDS - 1))) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // Registered count: a same-edge push into an empty buffer is not visible here
                if (count != 2'd0) begin
                    next_word  = buf_mem[rd_ptr];
                    next_valid = 1'b1;
                    pop        = load;
                end
            end
            default: begin
                state_next = SYNC;
            end
        endcase
    end

    // Serializer, preamble counter and buffer bookkeeping
    always_ff @(posedge clk16f or posedge reset) begin
        if (reset) begin
            phase      <= 2'd0;
            sync_cnt   <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
            shreg      <= '0;
            data_out   <= 2'b00;
            word_start <= 1'b0;
            valid_out  <= 1'b0;
            sync_done  <= 1'b0;
        end else begin
            phase <= phase + 2'd1;
            if (load) begin
                data_out   <= next_word[7:6];
                shreg      <= next_word[5:0];
                word_start <= 1'b1;
                valid_out  <= next_valid;
                if (state == SYNC) begin
                    sync_cnt <= sync_cnt + CNT_W'(1);
                end else begin
                    sync_done <= 1'b1;
                end
            end else begin
                data_out   <= shreg[5:4];
                shreg      <= {shreg[3:0], 2'b00};
                word_start <= 1'b0;
            end
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // Buffer storage needs no reset; occupancy alone qualifies it
    always_ff @(posedge clk16f) begin
        if (push) begin
            buf_mem[wr_ptr] <= data_in;
        end
    end

endmodule
